// File: rtl/mc_fetch_stage.sv
// mc_fetch_stage: PC / OldPC / IR / MDR holder for the multicycle RV32 core with a req/ack memory port.
// Optional macro FETCH_TIMEOUT_EN: abort an access that sees no ack within TIMEOUT cycles.
module mc_fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ir_write,
  input  logic            rd_start,
  input  logic            pc_update,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] data_reg,
  output logic            stall,
  output logic            proto_err,
  output logic            bus_err,
  output logic [1:0]      dbg_state
);

  // Handshake: mem_req rises on the edge that accepts a start pulse and stays high,
  // with mem_addr frozen, up to and including the edge that samples mem_ack=1.
  // One ack completes one request; an ack seen while idle is ignored.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_LOAD = 2'd2} state_e;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_pc_q, old_pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            proto_q, proto_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_q, bus_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_update ? result : pc_q;
    old_pc_d = old_pc_q;
    instr_d  = instr_q;
    data_d   = data_q;
    addr_d   = addr_q;
    req_d    = req_q;
    proto_d  = proto_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    bus_d    = bus_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Fetch captures the pre-update PC even when pc_update fires on the same edge.
        if (ir_write) begin
          state_d  = S_FETCH;
          addr_d   = pc_q;
          old_pc_d = pc_q;
          req_d    = 1'b1;
          proto_d  = proto_q | rd_start;
        end else if (rd_start) begin
          state_d = S_LOAD;
          addr_d  = result;
          req_d   = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      default: begin
        if (ir_write || rd_start) proto_d = 1'b1;
        if (mem_ack) begin
          if (state_q == S_FETCH) instr_d = mem_rdata;
          else                    data_d  = mem_rdata;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          if (state_q == S_FETCH) instr_d = NOP;
          else                    data_d  = '0;
          req_d   = 1'b0;
          bus_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      old_pc_q <= '0;
      instr_q  <= NOP;
      data_q   <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      proto_q  <= proto_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      bus_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bus_q <= bus_d;
    end
  end
  assign bus_err = bus_q;
`else
  assign bus_err = 1'b0;
`endif

  // stall is the request flag itself: an access is outstanding exactly while mem_req is high.
  assign mem_req   = req_q;
  assign stall     = req_q;
  assign mem_addr  = addr_q;
  assign pc        = pc_q;
  assign old_pc    = old_pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[6:0];
  assign data_reg  = data_q;
  assign proto_err = proto_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_fetch_stage.sv
// Randomized bench for mc_fetch_stage: a memory responder plus a transaction-level model of PC/IR/MDR.
module tb_mc_fetch_stage;

  localparam int          TIMEOUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_TIMEOUT_EN
  localparam int MAX_LAT = TIMEOUT - 1;
`else
  localparam int MAX_LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_write, rd_start, pc_update, mem_ack;
  logic [31:0] result, mem_rdata;
  logic        mem_req, stall, proto_err, bus_err;
  logic [31:0] mem_addr, pc, old_pc, instr, data_reg;
  logic [6:0]  opcode;
  logic [1:0]  dbg_state;

  mc_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ir_write(ir_write), .rd_start(rd_start), .pc_update(pc_update),
    .result(result), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_addr(mem_addr), .pc(pc), .old_pc(old_pc), .instr(instr), .opcode(opcode),
    .data_reg(data_reg), .stall(stall), .proto_err(proto_err), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_pc, m_old_pc, m_instr, m_data;
  bit          m_proto, m_bus;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_old_pc = '0; m_instr = NOP; m_data = '0;
    m_proto = 1'b0; m_bus = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".old_pc"}, old_pc, m_old_pc);
    check({tag, ".instr"}, instr, m_instr);
    check({tag, ".opcode"}, 32'(opcode), 32'(m_instr[6:0]));
    check({tag, ".data"}, data_reg, m_data);
    check({tag, ".req"}, 32'(mem_req), 32'd0);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    check({tag, ".proto"}, 32'(proto_err), 32'(m_proto));
    check({tag, ".bus"}, 32'(bus_err), 32'(m_bus));
  endtask

  task automatic check_busy(input string tag, input logic [31:0] addr);
    check({tag, ".req"}, 32'(mem_req), 32'd1);
    check({tag, ".stall"}, 32'(stall), 32'd1);
    check({tag, ".addr"}, mem_addr, addr);
    check({tag, ".old_pc"}, old_pc, m_old_pc);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".proto"}, 32'(proto_err), 32'(m_proto));
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_update = 1'b1; result = v;
    @(negedge clk);
    pc_update = 1'b0; result = $urandom;
    m_pc = v;
    check("set_pc", pc, m_pc);
  endtask

  // One complete access: start pulse, lat cycles without ack, then ack.
  task automatic access(input bit is_fetch, input bit both, input bit upd,
                        input logic [31:0] res, input int lat, input bit poke);
    logic [31:0] addr, got;
    ir_write = is_fetch; rd_start = !is_fetch || both; pc_update = upd; result = res;
    if (is_fetch) begin
      addr = m_pc; m_old_pc = m_pc;
      if (both) m_proto = 1'b1;
    end else begin
      addr = res;
    end
    if (upd) m_pc = res;
    exp_q.push_back(mem_read(addr));
    @(negedge clk);
    ir_write = 1'b0; rd_start = 1'b0; pc_update = 1'b0;
    check_busy("start", addr);
    for (int i = 0; i < lat; i++) begin
      if (poke && i == 0) begin
        if ($urandom_range(0, 1) == 1) ir_write = 1'b1; else rd_start = 1'b1;
        m_proto = 1'b1;
        result = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        pc_update = 1'b1; result = $urandom & 32'hFFFF_FFFC; m_pc = result;
      end
      @(negedge clk);
      ir_write = 1'b0; rd_start = 1'b0; pc_update = 1'b0;
      check_busy("wait", addr);
    end
    mem_ack = 1'b1; mem_rdata = mem_read(mem_addr);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    got = exp_q.pop_front();
    if (is_fetch) m_instr = got; else m_data = got;
    check_all("done");
  endtask

  task automatic reset_mid(input bit busy);
    if (busy) begin
      ir_write = 1'b1;
      @(negedge clk);
      ir_write = 1'b0;
      check("req_pre_rst", 32'(mem_req), 32'd1);
    end
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all("after_rst");
  endtask

  task automatic spurious_ack();
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    check_all("idle_ack");
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic timeout_access(input bit is_fetch);
    logic [31:0] addr;
    ir_write = is_fetch; rd_start = !is_fetch; result = 32'h0000_0300;
    addr = is_fetch ? m_pc : 32'h0000_0300;
    if (is_fetch) m_old_pc = m_pc;
    @(negedge clk);
    ir_write = 1'b0; rd_start = 1'b0;
    check_busy("to_start", addr);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (i < TIMEOUT - 1) begin
        check_busy("to_wait", addr);
      end else begin
        m_bus = 1'b1;
        if (is_fetch) m_instr = NOP; else m_data = '0;
        check_all("to_abort");
      end
    end
  endtask
`endif

  initial begin
    int op;
    rst = 1'b0; ir_write = 1'b0; rd_start = 1'b0; pc_update = 1'b0; mem_ack = 1'b0;
    result = '0; mem_rdata = '0;
    model_reset();
    mem[32'h0000_0010] = 32'h00A0_0093;
    mem[32'h0000_0200] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    reset_mid(1'b1);
    set_pc(32'h0000_0010);
    access(1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0);
    check("fetch0.instr", instr, 32'h00A0_0093);
    check("fetch0.old_pc", old_pc, 32'h0000_0010);
    access(1'b0, 1'b0, 1'b0, 32'h0000_0200, 3, 1'b0);
    check("load3.data", data_reg, 32'hDEAD_BEEF);
    spurious_ack();
    access(1'b1, 1'b1, 1'b0, 32'h0000_0200, 2, 1'b1);
    set_pc(32'h0000_0020);
    access(1'b1, 1'b0, 1'b1, 32'h0000_0024, 1, 1'b0);
    reset_mid(1'b0);

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: access(1'b1, 1'b0, ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC,
                           $urandom_range(0, MAX_LAT), ($urandom_range(0, 7) == 0));
        4, 5, 6:    access(1'b0, 1'b0, ($urandom_range(0, 3) == 0), $urandom,
                           $urandom_range(0, MAX_LAT), ($urandom_range(0, 7) == 0));
        7:          set_pc($urandom & 32'hFFFF_FFFC);
        8:          spurious_ack();
        default: begin
          if ($urandom_range(0, 2) == 0) reset_mid($urandom_range(0, 1) == 1);
          else access(1'b1, 1'b1, 1'b0, $urandom, $urandom_range(1, MAX_LAT), 1'b0);
        end
      endcase
    end

`ifdef FETCH_TIMEOUT_EN
    reset_mid(1'b0);
    access(1'b1, 1'b0, 1'b0, 32'h0, TIMEOUT - 1, 1'b0);
    timeout_access(1'b1);
    access(1'b0, 1'b0, 1'b0, 32'h0000_0200, 1, 1'b0);
    timeout_access(1'b0);
`else
    access(1'b0, 1'b0, 1'b0, 32'h0000_0200, 12, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
